// File: rtl/inst_fetch_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the IF stage and
// the memory controller's instruction read port. Hits return one cycle after
// the request; misses read a single word, fill the line, then return it.
// Data-side stores are snooped to invalidate stale lines.
module inst_fetch_cache #(
  parameter int unsigned IdxW = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rdy_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_i,
  input  logic        inv_all_i,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        if_stall_o,
  output logic        inst_re_o,
  output logic [31:0] inst_raddr_o,
  input  logic [31:0] inst_rdata_i,
  input  logic        inst_rbusy_i,
  input  logic        snoop_we_i,
  input  logic [31:0] snoop_addr_i
);

  localparam int unsigned Lines = 1 << IdxW;
  localparam int unsigned TagW  = 30 - IdxW;

  typedef enum logic [1:0] {StIdle, StReq, StWaitB, StWaitD} state_e;

  state_e            state_q, state_d;
  logic [Lines-1:0]  valid_q, valid_d;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [31:0]       data_q [Lines];
  logic [29:0]       waddr_q, waddr_d;   // latched fetch word address
  logic              drop_q, drop_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;

  logic [IdxW-1:0]   req_idx, miss_idx, snp_idx;
  logic [TagW-1:0]   req_tag, miss_tag, snp_tag;
  logic              lookup_hit, accept, fill, snoop_en, snoop_line_hit, snoop_miss_hit;
  logic              unused_addr_bits;

  assign req_idx  = if_addr_i[IdxW+1:2];
  assign req_tag  = if_addr_i[31:IdxW+2];
  assign miss_idx = waddr_q[IdxW-1:0];
  assign miss_tag = waddr_q[29:IdxW];
  assign snp_idx  = snoop_addr_i[IdxW+1:2];
  assign snp_tag  = snoop_addr_i[31:IdxW+2];

  // Byte offsets are irrelevant for word fetches and word-granular snoops.
  assign unused_addr_bits = ^{if_addr_i[1:0], snoop_addr_i[1:0]};

  // Lookup is on the pre-edge array, so coincident snoop/inv_all do not affect it.
  assign lookup_hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept         = (state_q == StIdle) && if_req_i && rdy_i && !flush_i;
  assign fill           = (state_q == StWaitD) && rdy_i && !inst_rbusy_i;
  assign snoop_en       = snoop_we_i && rdy_i;
  assign snoop_line_hit = snoop_en && valid_q[snp_idx] && (tag_q[snp_idx] == snp_tag);
  assign snoop_miss_hit = snoop_en && (snoop_addr_i[31:2] == waddr_q);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; everything holds while rdy_i is low.
  always_comb begin
    state_d = state_q;
    if (rdy_i) begin
      unique case (state_q)
        StIdle:  if (accept && !lookup_hit) state_d = StReq;
        StReq:   state_d = StWaitB;
        StWaitB: if (inst_rbusy_i) state_d = StWaitD;
        StWaitD: if (!inst_rbusy_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    if_stall_o = (state_q != StIdle);
    inst_re_o  = (state_q == StReq) && rdy_i;
  end

  // Datapath next-state: fetch latch, delivery, drop flag and valid bits.
  always_comb begin
    waddr_d    = waddr_q;
    drop_d     = drop_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    valid_d    = valid_q;
    if (rdy_i) begin
      if_valid_d = 1'b0;
      if (accept) begin
        waddr_d = if_addr_i[31:2];
        if (lookup_hit) begin
          if_inst_d  = data_q[req_idx];
          if_valid_d = 1'b1;
        end else begin
          drop_d = 1'b0;
        end
      end
      if ((state_q != StIdle) && (flush_i || snoop_miss_hit)) drop_d = 1'b1;
      if (fill) begin
        if_inst_d         = inst_rdata_i;
        // Same-cycle flush or store to the miss address also suppresses delivery.
        if_valid_d        = !(drop_q || flush_i || snoop_miss_hit);
        valid_d[miss_idx] = 1'b1;
      end
      if (snoop_line_hit) valid_d[snp_idx] = 1'b0;
      // A store racing the fill may carry newer data than the word being written.
      if (fill && snoop_en && (snp_idx == miss_idx)) valid_d[miss_idx] = 1'b0;
      if (inv_all_i) valid_d = '0;
    end
  end

  // Datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      waddr_q    <= '0;
      drop_q     <= 1'b0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      waddr_q    <= waddr_d;
      drop_q     <= drop_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= inst_rdata_i;
    end
  end

  assign if_inst_o    = if_inst_q;
  assign if_valid_o   = if_valid_q;
  assign inst_raddr_o = {waddr_q, 2'b00};

endmodule
